// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the two-port memory arbiter.
//   state_t   - arbiter FSM states
//   port_t    - requester identity (instruction / data)
//   mem_cmd_t - payload presented on the shared-memory port
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef struct packed {
        logic [WE_W-1:0]   we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between the two requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN defined -> alternate on contention,
// otherwise the data port always wins a tie.
// Ports:
//   i_elig, d_elig - per-port eligibility for this cycle
//   last_grant     - port granted most recently
//   valid_c        - at least one port is eligible
//   win_c          - selected port (meaningful only when valid_c=1)
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic  i_elig,
    input  logic  d_elig,
    input  port_t last_grant,
    output logic  valid_c,
    output port_t win_c
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority never consults the grant history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Winner select: single requester wins outright; ties resolved by build option.
    always_comb begin
        valid_c = i_elig | d_elig;
        win_c   = PORT_D;
        if (i_elig && d_elig) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_c = (last_grant == PORT_I) ? PORT_D : PORT_I;
`else
            win_c = PORT_D;
`endif
        end else if (i_elig) begin
            win_c = PORT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction read port and
// a data read/write port. One transaction in flight; all outputs registered.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
// Ports:
//   clk, rst                      - clock, async active-low reset
//   i_req/i_addr/i_rdata/i_done   - instruction port
//   d_req/d_we/d_addr/d_wdata     - data port request
//   d_rdata/d_done                - data port response
//   m_req/m_we/m_addr/m_wdata     - shared-memory request
//   m_rdata/m_ready               - shared-memory response
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic [WE_W-1:0]   d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              m_req,
    output logic [WE_W-1:0]   m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready
);

    state_t      state_q, state_d;
    port_t       last_q, last_d;
    mem_cmd_t    cmd_d;
    logic        m_req_d, i_done_d, d_done_d;
    logic [DATA_W-1:0] i_rdata_d, d_rdata_d;

    logic        i_elig, d_elig, turnaround;
    logic        grant_valid_c;
    port_t       grant_win_c;

    // A requester sees its done pulse while dropping req; mask it from arbitration.
    assign i_elig = i_req & ~i_done;
    assign d_elig = d_req & ~d_done;
    // The done cycle is a turnaround slot: no grant until both done pulses are clear.
    assign turnaround = i_done | d_done;

    mem_arb_pick u_pick (
        .i_elig     (i_elig),
        .d_elig     (d_elig),
        .last_grant (last_q),
        .valid_c    (grant_valid_c),
        .win_c      (grant_win_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        m_req_d   = m_req;
        cmd_d     = '{we: m_we, addr: m_addr, wdata: m_wdata};
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata;
        d_rdata_d = d_rdata;
        case (state_q)
            IDLE: begin
                if (grant_valid_c && !turnaround) begin
                    m_req_d = 1'b1;
                    last_d  = grant_win_c;
                    if (grant_win_c == PORT_D) begin
                        state_d = BUSY_D;
                        cmd_d   = '{we: d_we, addr: d_addr, wdata: d_wdata};
                    end else begin
                        state_d = BUSY_I;
                        cmd_d   = '{we: '0, addr: i_addr, wdata: '0};
                    end
                end
            end
            BUSY_I: begin
                if (m_ready) begin
                    i_rdata_d = m_rdata;
                    i_done_d  = 1'b1;
                    m_req_d   = 1'b0;
                    state_d   = IDLE;
                end
            end
            BUSY_D: begin
                if (m_ready) begin
                    d_rdata_d = m_rdata;
                    d_done_d  = 1'b1;
                    m_req_d   = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= PORT_I;
            m_req   <= 1'b0;
            m_we    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            m_req   <= m_req_d;
            m_we    <= cmd_d.we;
            m_addr  <= cmd_d.addr;
            m_wdata <= cmd_d.wdata;
            i_done  <= i_done_d;
            d_done  <= d_done_d;
            i_rdata <= i_rdata_d;
            d_rdata <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors and corner-case sequences for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req = 1'b0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_req;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_done  (i_done),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [3:0]  d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_ready;
        logic [31:0] m_rdata;
        logic        e_m_req;
        logic [3:0]  e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic        e_i_done;
        logic        e_d_done;
        logic [31:0] e_i_rdata;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m_req"},   32'(m_req),   32'h0);
        check({tag, " m_we"},    32'(m_we),    32'h0);
        check({tag, " m_addr"},  m_addr,       32'h0);
        check({tag, " m_wdata"}, m_wdata,      32'h0);
        check({tag, " i_done"},  32'(i_done),  32'h0);
        check({tag, " d_done"},  32'(d_done),  32'h0);
        check({tag, " i_rdata"}, i_rdata,      32'h0);
        check({tag, " d_rdata"}, d_rdata,      32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rises;
        int last_rise;
        int n_grant;
        logic prev_m_req;
        logic prev_i_done;
        logic [31:0] grants [4];
        logic [31:0] exp_g;

        // {inputs} | {expected outputs after the next rising edge}
        vecs[0] = '{1'b0, 32'h0,   1'b0, 4'b0000, 32'h0,   32'h0,        1'b1, 32'hDEAD0000,
                    1'b0, 4'b0000, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 32'h100, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b1, 32'h00500093,
                    1'b1, 4'b0000, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[2] = '{1'b1, 32'h100, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b1, 32'h00500093,
                    1'b0, 4'b0000, 32'h100, 32'h0,        1'b1, 1'b0, 32'h00500093, 32'h0};
        vecs[3] = '{1'b0, 32'h100, 1'b0, 4'b0000, 32'h0,   32'h0,        1'b1, 32'h00500093,
                    1'b0, 4'b0000, 32'h100, 32'h0,        1'b0, 1'b0, 32'h00500093, 32'h0};
        vecs[4] = '{1'b0, 32'h0,   1'b1, 4'b0100, 32'h204, 32'h00AB0000, 1'b1, 32'h11111111,
                    1'b1, 4'b0100, 32'h204, 32'h00AB0000, 1'b0, 1'b0, 32'h00500093, 32'h0};
        vecs[5] = '{1'b0, 32'h0,   1'b1, 4'b0100, 32'h204, 32'h00AB0000, 1'b1, 32'h11111111,
                    1'b0, 4'b0100, 32'h204, 32'h00AB0000, 1'b0, 1'b1, 32'h00500093, 32'h11111111};
        vecs[6] = '{1'b0, 32'h0,   1'b0, 4'b0100, 32'h204, 32'h00AB0000, 1'b1, 32'h11111111,
                    1'b0, 4'b0100, 32'h204, 32'h00AB0000, 1'b0, 1'b0, 32'h00500093, 32'h11111111};

        // Reset state, before any clock edge.
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Table: idle, instruction read, data byte write.
        for (int v = 0; v < 7; v++) begin
            i_req   = vecs[v].i_req;
            i_addr  = vecs[v].i_addr;
            d_req   = vecs[v].d_req;
            d_we    = vecs[v].d_we;
            d_addr  = vecs[v].d_addr;
            d_wdata = vecs[v].d_wdata;
            m_ready = vecs[v].m_ready;
            m_rdata = vecs[v].m_rdata;
            tick();
            check($sformatf("vec%0d m_req", v),   32'(m_req),   32'(vecs[v].e_m_req));
            check($sformatf("vec%0d m_we", v),    32'(m_we),    32'(vecs[v].e_m_we));
            check($sformatf("vec%0d m_addr", v),  m_addr,       vecs[v].e_m_addr);
            check($sformatf("vec%0d m_wdata", v), m_wdata,      vecs[v].e_m_wdata);
            check($sformatf("vec%0d i_done", v),  32'(i_done),  32'(vecs[v].e_i_done));
            check($sformatf("vec%0d d_done", v),  32'(d_done),  32'(vecs[v].e_d_done));
            check($sformatf("vec%0d i_rdata", v), i_rdata,      vecs[v].e_i_rdata);
            check($sformatf("vec%0d d_rdata", v), d_rdata,      vecs[v].e_d_rdata);
        end

        // Wait states: data read at 0x40, m_ready low for 3 cycles; inputs wiggle while busy.
        d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h40; d_wdata = 32'h0;
        m_ready = 1'b0; m_rdata = 32'hCAFEF00D;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wait%0d m_req", k),  32'(m_req),  32'h1);
            check($sformatf("wait%0d m_addr", k), m_addr,      32'h40);
            check($sformatf("wait%0d m_we", k),   32'(m_we),   32'h0);
            check($sformatf("wait%0d d_done", k), 32'(d_done), 32'h0);
            d_addr  = 32'h999;
            d_we    = 4'b1111;
            m_ready = (k == 3);
            tick();
        end
        check("wait d_done pulse", 32'(d_done), 32'h1);
        check("wait d_rdata",      d_rdata,     32'hCAFEF00D);
        check("wait m_req clear",  32'(m_req),  32'h0);
        d_req = 1'b0; d_we = 4'b0000; m_ready = 1'b1;
        tick();
        check("wait d_done single", 32'(d_done), 32'h0);
        check("wait idle m_req",    32'(m_req),  32'h0);

        // Done masking: continuous instruction requester, one grant per 3 cycles.
        i_req = 1'b1; i_addr = 32'h100; m_ready = 1'b1; m_rdata = 32'h00500093;
        rises = 0; last_rise = 0;
        prev_m_req = m_req; prev_i_done = i_done;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (prev_i_done) check($sformatf("mask c%0d no grant", c), 32'(m_req), 32'h0);
            if (m_req && !prev_m_req) begin
                rises++;
                if (last_rise > 0) check($sformatf("mask c%0d spacing", c), 32'(c - last_rise), 32'd3);
                last_rise = c;
            end
            prev_m_req  = m_req;
            prev_i_done = i_done;
        end
        check("mask rise count", 32'(rises), 32'd3);
        i_req = 1'b0;
        tick();

        // Simultaneous requests straight out of reset.
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_addr = 32'h400; d_we = 4'b0000;
        m_ready = 1'b1;
        tick();
        check("sim in reset m_req", 32'(m_req), 32'h0);
        rst = 1'b1;
        n_grant = 0; prev_m_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (m_req && !prev_m_req) begin
                if (n_grant == 0) check("sim first grant cycle", 32'(c), 32'd1);
                if (n_grant < 4) grants[n_grant] = m_addr;
                n_grant++;
            end
            check($sformatf("sim c%0d done exclusive", c), 32'(i_done & d_done), 32'h0);
            prev_m_req = m_req;
        end
        check("sim grant count", 32'(n_grant), 32'd4);
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (g % 2 == 0) ? 32'h400 : 32'h300;
`else
            exp_g = 32'h400;
`endif
            if (g < n_grant) check($sformatf("sim grant%0d addr", g), grants[g], exp_g);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        // Reset in the middle of a data transaction.
        d_req = 1'b1; d_addr = 32'h80; d_we = 4'b0000; m_ready = 1'b0;
        tick();
        check("rstmid busy m_req", 32'(m_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rstmid async");
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("rstmid hold%0d d_done", c), 32'(d_done), 32'h0);
            check($sformatf("rstmid hold%0d m_req", c),  32'(m_req),  32'h0);
        end
        rst = 1'b1; d_addr = 32'h88; m_ready = 1'b1; m_rdata = 32'h5A5A5A5A;
        tick();
        check("rstmid regrant m_req",  32'(m_req), 32'h1);
        check("rstmid regrant m_addr", m_addr,     32'h88);
        tick();
        check("rstmid done",    32'(d_done), 32'h1);
        check("rstmid d_rdata", d_rdata,     32'h5A5A5A5A);
        d_req = 1'b0;
        tick();
        check("rstmid done single", 32'(d_done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
